// File: rtl/mxu_pkg.sv
// Shared types and constants for the MXU result drain stage.
// Optional feature macro: MXU_DRAIN_ACCUM_EN (K-tile accumulation before commit).
package mxu_pkg;

  localparam int BIT_WIDTH = 4;
  localparam int DIM       = 2;
  localparam int ACC_GUARD = 2;
  localparam int OUT_W     = 2 * BIT_WIDTH;
  localparam int DATA_W    = OUT_W + ACC_GUARD;
  localparam int NUM_ELEM  = DIM * DIM;
  localparam int IDX_W     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int RC_W      = (DIM > 1) ? $clog2(DIM) : 1;

  typedef logic [OUT_W-1:0] res_elem_t;
  // Element [0][0] occupies the most significant slice of the packed matrix.
  typedef res_elem_t [0:DIM-1][0:DIM-1] res_mat_t;

  typedef logic [DATA_W-1:0] acc_elem_t;
  typedef acc_elem_t [0:DIM-1][0:DIM-1] acc_mat_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Row-major flat index to row / column.
  function automatic logic [RC_W-1:0] idx_row(input logic [IDX_W-1:0] idx);
    return RC_W'(int'(idx) / DIM);
  endfunction

  function automatic logic [RC_W-1:0] idx_col(input logic [IDX_W-1:0] idx);
    return RC_W'(int'(idx) % DIM);
  endfunction

endpackage

// File: rtl/mxu_drain_bank.sv
// One ping-pong bank: a full matrix store plus its FULL flag.
// A write and a clear in the same cycle leave the bank FULL with the new data,
// which is how a freed bank accepts a result on the final handshake.
module mxu_drain_bank
  import mxu_pkg::*;
#(
  parameter int W = OUT_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [0:DIM-1][0:DIM-1][W-1:0]     wr_data,
  input  logic                               clr_en,
  input  logic [RC_W-1:0]                    rd_row,
  input  logic [RC_W-1:0]                    rd_col,
  output logic [W-1:0]                       rd_data,
  output logic                               full
);

  logic [0:DIM-1][0:DIM-1][W-1:0] mem_reg;
  logic                           full_reg;

  // Capture the whole matrix in one cycle on a write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_reg <= '0;
    end else if (wr_en) begin
      mem_reg <= wr_data;
    end
  end

  // Full flag: write has priority over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_reg <= 1'b0;
    end else if (wr_en) begin
      full_reg <= 1'b1;
    end else if (clr_en) begin
      full_reg <= 1'b0;
    end
  end

  assign rd_data = mem_reg[rd_row][rd_col];
  assign full    = full_reg;

endmodule

// File: rtl/mxu_result_drain.sv
// Captures MXU result matrices into a two-bank ping-pong buffer and streams
// them out row-major over valid/ready. Results arriving with no free bank are
// dropped and flagged on the sticky overflow output.
// Optional feature macro: MXU_DRAIN_ACCUM_EN -- sums in_valid matrices in a
// DATA_W accumulator and commits on acc_last.
module mxu_result_drain
  import mxu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  res_mat_t          in_data,
  input  logic              acc_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [RC_W-1:0]   m_row,
  output logic [RC_W-1:0]   m_col,
  output logic              m_last,
  output logic              overflow,
  output logic              busy
);

`ifdef MXU_DRAIN_ACCUM_EN
  localparam int ST_W = DATA_W;
`else
  localparam int ST_W = OUT_W;
`endif

  logic                              commit_vld;
  logic [0:DIM-1][0:DIM-1][ST_W-1:0] commit_data;

`ifdef MXU_DRAIN_ACCUM_EN
  acc_mat_t acc_reg;
  acc_mat_t acc_sum;

  for (genvar gi = 0; gi < DIM; gi++) begin : g_acc_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_acc_col
      // Element-wise sum, wrapping modulo 2^DATA_W.
      assign acc_sum[gi][gj] = acc_reg[gi][gj] + DATA_W'(in_data[gi][gj]);
    end
  end

  // Running sum; clears once the final K-tile has been folded in and committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (in_valid) begin
      acc_reg <= acc_last ? '0 : acc_sum;
    end
  end

  assign commit_vld  = in_valid && acc_last;
  assign commit_data = acc_sum;
`else
  logic unused_acc_last;
  assign unused_acc_last = acc_last;
  assign commit_vld      = in_valid;
  assign commit_data     = in_data;
`endif

  drain_state_e     state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             rd_bank_reg, rd_bank_next;
  logic             wr_bank_reg, wr_bank_next;
  logic             overflow_reg, overflow_next;

  logic [1:0]       bank_full;
  logic [1:0]       bank_wr;
  logic [1:0]       bank_clr;
  logic [ST_W-1:0]  bank_rd [2];

  logic             active;
  logic             hs;
  logic             is_last;
  logic             final_hs;
  logic             commit_free;
  logic             commit_ok;

  // Valid is raised as soon as the read bank fills, giving one-cycle latency.
  assign active      = (state_reg == DRAIN) || bank_full[rd_bank_reg];
  assign hs          = active && m_ready;
  assign is_last     = (idx_reg == IDX_W'(NUM_ELEM - 1));
  assign final_hs    = hs && is_last;
  // The bank being freed this cycle counts as free for an arriving result.
  assign commit_free = !bank_full[wr_bank_reg] || bank_clr[wr_bank_reg];
  assign commit_ok   = commit_vld && commit_free;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_wr[gi]  = commit_ok && (int'(wr_bank_reg) == gi);
    assign bank_clr[gi] = final_hs && (int'(rd_bank_reg) == gi);

    mxu_drain_bank #(
      .W (ST_W)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bank_wr[gi]),
      .wr_data (commit_data),
      .clr_en  (bank_clr[gi]),
      .rd_row  (idx_row(idx_reg)),
      .rd_col  (idx_col(idx_reg)),
      .rd_data (bank_rd[gi]),
      .full    (bank_full[gi])
    );
  end

  // State, index, bank pointers and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      rd_bank_reg  <= 1'b0;
      wr_bank_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      rd_bank_reg  <= rd_bank_next;
      wr_bank_reg  <= wr_bank_next;
      overflow_reg <= overflow_next;
    end
  end

  // Next-state: walk idx on handshakes, hop banks on the last element.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    rd_bank_next  = rd_bank_reg;
    wr_bank_next  = wr_bank_reg ^ commit_ok;
    overflow_next = overflow_reg | (commit_vld && !commit_free);

    case (state_reg)
      IDLE:    if (bank_full[rd_bank_reg]) state_next = DRAIN;
      DRAIN:   state_next = DRAIN;
      default: state_next = IDLE;
    endcase

    if (hs) begin
      if (is_last) begin
        idx_next     = '0;
        rd_bank_next = !rd_bank_reg;
        // Continue without a bubble only if the other bank already holds data.
        state_next   = bank_full[!rd_bank_reg] ? DRAIN : IDLE;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end
  end

  assign m_valid  = active;
  assign m_data   = active ? DATA_W'(bank_rd[rd_bank_reg]) : '0;
  assign m_row    = idx_row(idx_reg);
  assign m_col    = idx_col(idx_reg);
  assign m_last   = active && is_last;
  assign overflow = overflow_reg;
  assign busy     = |bank_full;

endmodule
